// File: rtl/coords_pkg.sv
// coords_pkg: shared definitions for the coordinate ROM sequencer.
// Field positions of the 36-bit ROM word, the terminator value and the
// sequencer state encoding.
package coords_pkg;

  localparam int RING_HI = 31;
  localparam int RING_LO = 28;
  localparam int IDX_HI  = 27;
  localparam int IDX_LO  = 24;
  localparam int X_HI    = 23;
  localparam int X_LO    = 12;
  localparam int Y_HI    = 11;
  localparam int Y_LO    = 0;

  localparam int COORD_W = 12;

  // All-zero word ends the table; bits [35:32] are reserved and ignored
  // for field extraction but still count toward the terminator compare.
  localparam logic [35:0] TERM_WORD = 36'h0;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/coords_seq.sv
// coords_seq: walks the coordinate ROM from address 0, absorbs its 1-cycle
// read latency and hands out one unpacked point at a time over valid/ready.
// Build option COORDS_SEQ_LOOP_EN: when defined, the sweep wraps back to
// address 0 instead of finishing, pulsing done on every wrap.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for start; address counter parked at 0
//  RD    | rom_ce high, ROM samples rom_ad at the end of this cycle
//  CAP   | rom_dout valid; terminator check, fields captured
//  HOLD  | point presented (pt_valid), waiting for pt_ready
//  DONE  | one-cycle done pulse, then back to IDLE
module coords_seq
  import coords_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [3:0]        pt_ring,
  output logic [3:0]        pt_idx,
  output logic [COORD_W-1:0] pt_x,
  output logic [COORD_W-1:0] pt_y,
  output logic              busy,
  output logic              done
);

`ifdef COORDS_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] addr;

  // The ROM output register is never gated; only rom_ce qualifies reads.
  assign rom_oce = 1'b1;

  // Sequencer FSM, address counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      rom_ce   <= 1'b0;
      rom_ad   <= '0;
      pt_valid <= 1'b0;
      pt_ring  <= '0;
      pt_idx   <= '0;
      pt_x     <= '0;
      pt_y     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop) begin
      // Abort: fields keep their last values, rom_ad holds to avoid toggling.
      state    <= IDLE;
      addr     <= '0;
      rom_ce   <= 1'b0;
      pt_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RD;
            rom_ce <= 1'b1;
            rom_ad <= addr;
            busy   <= 1'b1;
          end
        end
        RD: begin
          rom_ce <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          if (rom_dout == TERM_WORD) begin
            done <= 1'b1;
            if (LOOP_EN) begin
              state  <= RD;
              addr   <= '0;
              rom_ce <= 1'b1;
              rom_ad <= '0;
            end else begin
              state <= DONE;
            end
          end else begin
            pt_ring  <= rom_dout[RING_HI:RING_LO];
            pt_idx   <= rom_dout[IDX_HI:IDX_LO];
            pt_x     <= rom_dout[X_HI:X_LO];
            pt_y     <= rom_dout[Y_HI:Y_LO];
            pt_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            if (addr == LAST_ADDR) begin
              done <= 1'b1;
              if (LOOP_EN) begin
                state  <= RD;
                addr   <= '0;
                rom_ce <= 1'b1;
                rom_ad <= '0;
              end else begin
                state <= DONE;
              end
            end else begin
              addr   <= addr + 1'b1;
              rom_ad <= addr + 1'b1;
              rom_ce <= 1'b1;
              state  <= RD;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          addr  <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          addr   <= '0;
          rom_ce <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coords_seq.sv
// tb_coords_seq: directed bench for coords_seq with a behavioural
// synchronous ROM. Define COORDS_SEQ_LOOP_EN to exercise the looping build.
module tb_coords_seq;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pt_ready = 1'b0;
  logic        rom_ce, rom_oce;
  logic [3:0]  rom_ad;
  logic [35:0] rom_dout = '0;
  logic        pt_valid;
  logic [3:0]  pt_ring, pt_idx;
  logic [11:0] pt_x, pt_y;
  logic        busy, done;

  logic [35:0] rom_mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  coords_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .rom_ce   (rom_ce),
    .rom_oce  (rom_oce),
    .rom_ad   (rom_ad),
    .rom_dout (rom_dout),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_ring  (pt_ring),
    .pt_idx   (pt_idx),
    .pt_x     (pt_x),
    .pt_y     (pt_y),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous ROM
  always @(posedge clk) if (rom_ce && rom_oce) rom_dout <= rom_mem[rom_ad];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pt_word();
    return {pt_ring, pt_idx, pt_x, pt_y};
  endfunction

  // Start a sweep and consume points with ready high. Optionally stall on
  // point stall_at for 10 cycles, or abort with stop on point stop_at.
  task automatic run_sweep(input int stall_at, input int stop_at, input int exp_pts,
                           input int exp_reads, input int exp_dones);
    int cyc, n, p, reads, dones, rel_cyc;
    bit fin, loop_mode;
    cyc = 0; n = 0; p = 0; reads = 0; dones = 0; rel_cyc = 0; fin = 1'b0;
`ifdef COORDS_SEQ_LOOP_EN
    loop_mode = 1'b1;
`else
    loop_mode = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1;
    pt_ready = 1'b1;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (rom_ce) begin
        chk("rd_addr", rom_ad, reads % 16);
        reads++;
      end
      if (done) begin
        dones++;
        if (loop_mode) begin
          chk("wrap_pts", p, exp_pts);
          p = 0;
        end else begin
          chk("sweep_pts", n, exp_pts);
          chk("sweep_reads", reads, exp_reads);
          @(negedge clk);
          chk("done_width", done, 0);
          chk("busy_after", busy, 0);
          fin = 1'b1;
        end
      end else if (pt_valid) begin
        chk("pt_data", pt_word(), rom_mem[p][31:0]);
        if (n == 0) chk("first_lat", cyc, 3);
        if (stall_at >= 0 && n == stall_at + 1) chk("stall_lat", cyc - rel_cyc, 3);
        if (n == stall_at) begin
          pt_ready = 1'b0;
          repeat (10) begin
            @(negedge clk);
            cyc++;
            chk("stall_valid", pt_valid, 1);
            chk("stall_data", pt_word(), rom_mem[p][31:0]);
            chk("stall_ce", rom_ce, 0);
            chk("stall_ad", rom_ad, p);
          end
          pt_ready = 1'b1;
          rel_cyc = cyc;
        end
        if (n == stop_at) begin
          stop = 1'b1;
          @(negedge clk);
          stop = 1'b0;
          chk("stop_valid", pt_valid, 0);
          chk("stop_busy", busy, 0);
          chk("stop_done", done, 0);
          chk("stop_ce", rom_ce, 0);
          @(negedge clk);
          chk("stop_nodone", done, 0);
          chk("stop_dones", dones, exp_dones);
          fin = 1'b1;
        end
        n++;
        p++;
      end
    end
    chk("sweep_end", fin, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, pt_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ce"}, rom_ce, 0);
    chk({tag, "_ad"}, rom_ad, 0);
    chk({tag, "_fields"}, pt_word(), 0);
    chk({tag, "_oce"}, rom_oce, 1);
  endtask

  initial begin : main
    int seen, cyc;
    // {rsvd, ring, idx, x, y}; entry 2 carries reserved bits that must be ignored
    rom_mem[0]  = 36'h0_0_1_996_478;
    rom_mem[1]  = 36'h0_0_2_9A1_4C0;
    rom_mem[2]  = 36'hA_0_3_97F_50A;
    rom_mem[3]  = 36'h0_0_4_94C_53C;
    rom_mem[4]  = 36'h0_0_5_90A_55E;
    rom_mem[5]  = 36'h0_0_6_8C4_560;
    rom_mem[6]  = 36'h0_0_7_8F0_4F2;
    rom_mem[7]  = 36'h0_0_8_913_448;
    rom_mem[8]  = 36'h0_1_1_806_478;
    rom_mem[9]  = 36'h0_1_2_7C2_4E0;
    rom_mem[10] = 36'h0_1_3_740_510;
    rom_mem[11] = 36'h0_1_4_6B5_52A;
    rom_mem[12] = 36'h0_1_5_62F_512;
    rom_mem[13] = 36'h0_1_6_5C8_4D0;
    rom_mem[14] = 36'h0_1_7_55A_448;
    rom_mem[15] = 36'h0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");

`ifdef COORDS_SEQ_LOOP_EN
    // two full loops, stop on entry 0 of the third
    run_sweep(-1, 30, 15, 0, 2);
`else
    run_sweep(-1, -1, 15, 16, 0);
    run_sweep(3, -1, 15, 16, 0);
    rom_mem[15] = 36'h0_1_8_2F0_3A4;
    run_sweep(-1, -1, 16, 16, 0);
    rom_mem[15] = 36'h0;
`endif

    // abort on entry 5, then restart from address 0
    run_sweep(-1, 5, 0, 0, 0);
    run_sweep(-1, 0, 0, 0, 0);

    // reset during CAP of entry 3 with start held high
    @(negedge clk);
    start = 1'b1;
    pt_ready = 1'b1;
    seen = 0;
    cyc = 0;
    while (seen < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (pt_valid) seen++;
    end
    chk("pre_reset_pts", seen, 3);
    @(negedge clk);
    chk("pre_reset_rd", rom_ce, 1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_reset_vals("cap_rst");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_ce", rom_ce, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ss_idle", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
